fib_frame_stack: RTL
====================

Name: fib_frame_stack

Overview:
- Synchronous LIFO stack holding recursion frames (operand words) for the stack-based Fibonacci datapath.
- Storage is built from registered logic-cell flip-flops.
- Sits between the Fibonacci control FSM, which issues push and pop requests, and the adder datapath, which consumes the top-of-stack word.
- All outputs are registered; top-of-stack is always visible without a read strobe.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 8: number of stack entries; legal range 2 to 64.
- CNT_W, 4: width of the count output; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  clock, rising-edge active
- clr  input  1  asynchronous active-high reset
- push  input  1  push request, sampled at posedge clk
- pop  input  1  pop request, sampled at posedge clk
- din  input  WIDTH  data word to push
- tos  output  WIDTH  current top-of-stack word; 0 when empty
- nos  output  WIDTH  next-on-stack word (entry below top); 0 when count < 2
- count  output  CNT_W  number of valid entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- ack  output  1  one-cycle pulse: the request sampled last edge was accepted
- err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset: clk is the clock; clr is asynchronous and active-high.
  - While clr is high: tos=0, nos=0, count=0, empty=1, full=0, ack=0, err=0.
  - Memory contents are don't-care after reset.
  - clr asserted mid-operation aborts the operation; no partial write is visible.
- Operation decode at each posedge clk (clr low), using push and pop sampled at that edge:
  - IDLE (push=0, pop=0): no state change; ack=0.
  - PUSH (push=1, pop=0, !full): mem[count] <= din; count+1; tos <= din; nos <= old tos; ack=1.
  - POP (push=0, pop=1, !empty): count-1; tos <= old nos; nos <= mem[count-3], or 0 if new count < 2; ack=1.
  - REPLACE (push=1, pop=1, !empty): top entry overwritten with din; count unchanged; tos <= din; nos unchanged; ack=1. REPLACE is allowed when full.
  - push=1, pop=1 while empty: treated as PUSH; ack=1.
  - PUSH while full: ignored; no state change; ack=0; overflow event.
  - POP while empty: ignored; outputs unchanged; ack=0; underflow event.
- Latency: all effects are visible on outputs one clock after the sampling edge; no combinational input-to-output path.
- Status flags:
  - empty and full are registered and updated in the same cycle as count.
  - full and empty are never both 1.
- Count arithmetic: unsigned and saturating by construction (guarded ops only); never wraps.
- Requests are level-sampled. A request held high for N cycles performs N operations, each subject to the full/empty guards.

Optional Feature:
- Macro: FIB_FRAME_STACK_ERR_EN.
- Defined:
  - err is set on the cycle after any overflow or underflow event.
  - err stays 1 until clr.
  - Accepted operations do not clear err.
- Not defined:
  - err is tied to 0.
  - The error-detect logic is not instantiated.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: assert clr mid-cycle with no clk edge -> outputs clear immediately: tos=0, count=0, empty=1, err=0.
- Three pushes (WIDTH=8): push 0x01, 0x01, 0x02 on consecutive cycles -> after the third: tos=0x02, nos=0x01, count=3, ack high for 3 cycles.
- Pop sequence: from the prior state, pop twice -> tos=0x01/nos=0x00, count=1; then tos=0x01, count=1 becomes tos=0x01... specifically, after the 2nd pop: tos=0x01, nos=0, count=1. A 3rd pop -> empty=1, tos=0.
- Fill to DEPTH=8 with 0x10..0x17, then push 0xFF -> count=8, full=1, tos=0x17, ack=0; err=1 only with the macro.
- REPLACE: count=2 (tos=0x05, nos=0x03), push=pop=1 with din=0x08 -> tos=0x08, nos=0x03, count=2, ack=1.
- Pop on empty, then push+pop on empty with din=0x0D:
  - Pop -> ack=0, err=1 (macro only).
  - Push+pop -> tos=0x0D, count=1, ack=1.
  - Then assert clr during an active push -> count=0, err=0.

Source files
------------

// File: rtl/fib_frame_stack_if.sv
// Request/response bundle between the Fibonacci control FSM (master) and the
// frame stack (slave). WIDTH is the data word width, CNT_W the count width.
interface fib_frame_stack_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
);
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             ack;
   logic             err;

   modport master (
      output push, pop, din,
      input  tos, nos, count, empty, full, ack, err
   );

   modport slave (
      input  push, pop, din,
      output tos, nos, count, empty, full, ack, err
   );
endinterface

// File: rtl/fib_frame_stack.sv
// Flip-flop LIFO holding recursion frames for the stack-based Fibonacci datapath.
// Top and next-on-stack are kept in dedicated registers so both are visible
// without a read strobe; every output is registered.
// Optional sticky error flag: define FIB_FRAME_STACK_ERR_EN.
module fib_frame_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input logic              clk,
   input logic              clr,
   fib_frame_stack_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OpIdle,
      OpPush,
      OpPop,
      OpReplace,
      OpOverflow,
      OpUnderflow
   } op_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [WIDTH-1:0] nos_q, nos_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             ack_q, ack_d;
   logic [AW-1:0]    wr_idx, top_idx, nos_idx;
   op_e              op;

   assign wr_idx  = AW'(count_q);
   assign top_idx = AW'(count_q - CNT_W'(1));
   assign nos_idx = AW'(count_q - CNT_W'(3));

   // Classify the sampled request; push+pop on an empty stack degrades to a push.
   always_comb begin
      op = OpIdle;
      if (bus.push && (!bus.pop || empty_q)) begin
         op = full_q ? OpOverflow : OpPush;
      end else if (bus.push && bus.pop) begin
         op = OpReplace;
      end else if (bus.pop) begin
         op = empty_q ? OpUnderflow : OpPop;
      end
   end

   // Next state for storage, top/next registers, count and flags.
   always_comb begin
      mem_d   = mem_q;
      tos_d   = tos_q;
      nos_d   = nos_q;
      count_d = count_q;
      ack_d   = 1'b0;
      unique case (op)
         OpPush: begin
            mem_d[wr_idx] = bus.din;
            count_d       = count_q + CNT_W'(1);
            tos_d         = bus.din;
            nos_d         = tos_q;
            ack_d         = 1'b1;
         end
         OpPop: begin
            count_d = count_q - CNT_W'(1);
            tos_d   = nos_q;
            // The entry two below the old top becomes next-on-stack, if it exists.
            nos_d   = (count_q >= CNT_W'(3)) ? mem_q[nos_idx] : '0;
            ack_d   = 1'b1;
         end
         OpReplace: begin
            mem_d[top_idx] = bus.din;
            tos_d          = bus.din;
            ack_d          = 1'b1;
         end
         default: ;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_W'(DEPTH));
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mem_q   <= '{default: '0};
         tos_q   <= '0;
         nos_q   <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ack_q   <= ack_d;
      end
   end

`ifdef FIB_FRAME_STACK_ERR_EN
   logic err_q, err_d;

   // Sticky error: any rejected push or pop sets it until the next clear.
   always_comb begin
      err_d = err_q | (op == OpOverflow) | (op == OpUnderflow);
   end

   // Error flag register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.tos   = tos_q;
   assign bus.nos   = nos_q;
   assign bus.count = count_q;
   assign bus.empty = empty_q;
   assign bus.full  = full_q;
   assign bus.ack   = ack_q;
endmodule
